// File: rtl/fibo_pkg.sv
// fibo_pkg: shared state encoding, default term width/seeds and the term-sum helper
// for the Fibonacci stream checker.
package fibo_pkg;
  typedef enum logic [1:0] {IDLE, SEED, CHECK, FAIL} state_t;
  localparam int FIBO_WIDTH = 5;
  localparam int FIBO_SEED0 = 0;
  localparam int FIBO_SEED1 = 1;
  // Full-width sum with carry; callers truncate to their own WIDTH+1 bits.
  function automatic logic [32:0] fibo_sum(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/fibo_expect_unit.sv
// fibo_expect_unit: combinational next-term predictor (p1+p2 mod 2^WIDTH); the carry
// output exists only when FIBO_CHK_OVF_DETECT_EN is defined.
module fibo_expect_unit
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH
) (
  input  logic [WIDTH-1:0] p1_i,
  input  logic [WIDTH-1:0] p2_i,
`ifdef FIBO_CHK_OVF_DETECT_EN
  output logic             carry_o,
`endif
  output logic [WIDTH-1:0] expected_o
);
`ifdef FIBO_CHK_OVF_DETECT_EN
  assign {carry_o, expected_o} = (WIDTH+1)'(fibo_sum(32'(p1_i), 32'(p2_i)));
`else
  assign expected_o = WIDTH'(fibo_sum(32'(p1_i), 32'(p2_i)));
`endif
endmodule

// File: rtl/fibo_stream_checker.sv
// fibo_stream_checker: checks seeds and the Fibonacci recurrence on a valid-qualified term
// stream; optional sticky carry-out flag under FIBO_CHK_OVF_DETECT_EN.
module fibo_stream_checker
  import fibo_pkg::*;
#(
  parameter int               WIDTH      = FIBO_WIDTH,
  parameter int               CNT_W      = 8,
  parameter logic [WIDTH-1:0] SEED0      = WIDTH'(FIBO_SEED0),
  parameter logic [WIDTH-1:0] SEED1      = WIDTH'(FIBO_SEED1),
  parameter bit               CHECK_SEED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             locked,
  output logic             match,
  output logic             error,
  output logic [CNT_W-1:0] err_index,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_got,
  output logic [CNT_W-1:0] term_count,
  output logic             ovf
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] p1_q, p1_d, p2_q, p2_d, exp_q, exp_d, got_q, got_d, expected, fail_exp;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic match_q, match_d, error_q, error_d, accept, fail;
`ifdef FIBO_CHK_OVF_DETECT_EN
  logic carry, ovf_q, ovf_d;
`endif
  fibo_expect_unit #(.WIDTH(WIDTH)) u_expect (
    .p1_i      (p1_q),
    .p2_i      (p2_q),
`ifdef FIBO_CHK_OVF_DETECT_EN
    .carry_o   (carry),
`endif
    .expected_o(expected)
  );
  assign accept = in_valid && state_q != FAIL;
  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    match_d  = 1'b0;
    fail     = 1'b0;
    fail_exp = '0;
    cnt_d    = cnt_q;
`ifdef FIBO_CHK_OVF_DETECT_EN
    ovf_d    = ovf_q;
`endif
    if (accept) begin
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          p2_d     = in_data;
          fail     = CHECK_SEED && in_data != SEED0;
          fail_exp = SEED0;
          state_d  = SEED;
        end
        SEED: begin
          p1_d     = in_data;
          fail     = CHECK_SEED && in_data != SEED1;
          fail_exp = SEED1;
          state_d  = CHECK;
        end
        default: begin
          fail     = in_data != expected;
          fail_exp = expected;
          p2_d     = fail ? p2_q : p1_q;
          p1_d     = fail ? p1_q : in_data;
          match_d  = !fail;
`ifdef FIBO_CHK_OVF_DETECT_EN
          ovf_d    = ovf_q | carry;
`endif
        end
      endcase
      state_d = fail ? FAIL : state_d;
    end
    error_d = error_q | fail;
    idx_d   = fail ? cnt_q : idx_q;
    exp_d   = fail ? fail_exp : exp_q;
    got_d   = fail ? in_data : got_q;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      match_q <= 1'b0;
      error_q <= 1'b0;
      idx_q   <= '0;
      exp_q   <= '0;
      got_q   <= '0;
      cnt_q   <= '0;
`ifdef FIBO_CHK_OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      match_q <= match_d;
      error_q <= error_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      got_q   <= got_d;
      cnt_q   <= cnt_d;
`ifdef FIBO_CHK_OVF_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  assign locked       = state_q == CHECK;
  assign match        = match_q;
  assign error        = error_q;
  assign err_index    = idx_q;
  assign err_expected = exp_q;
  assign err_got      = got_q;
  assign term_count   = cnt_q;
`ifdef FIBO_CHK_OVF_DETECT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fibo_stream_checker.sv
// tb_fibo_stream_checker: randomized and directed checks of two checker instances
// (seed check on / off) against an index-based reference model of the term stream.
module tb_fibo_stream_checker;
  localparam int W = 5, CW = 8, MOD = 32, SAT = 255;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clear = 1'b0;
  logic [W-1:0] in_data = '0;
  logic locked [2], match [2], error [2], ovf [2];
  logic [CW-1:0] err_index [2], term_count [2];
  logic [W-1:0] err_expected [2], err_got [2];
  int vectors = 0, miscompares = 0;
  typedef struct {int n; int t1; int t2; int eidx; int eexp; int egot; bit failed; bit match; bit ovf;} mdl_t;
  mdl_t m [2];
  int seq [$];
  always #5 clk = ~clk;
  fibo_stream_checker u_chk0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked[0]), .match(match[0]), .error(error[0]), .err_index(err_index[0]),
    .err_expected(err_expected[0]), .err_got(err_got[0]), .term_count(term_count[0]), .ovf(ovf[0])
  );
  fibo_stream_checker #(.CHECK_SEED(1'b0)) u_chk1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked[1]), .match(match[1]), .error(error[1]), .err_index(err_index[1]),
    .err_expected(err_expected[1]), .err_got(err_got[1]), .term_count(term_count[1]), .ovf(ovf[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask
  // Reference: the k-th accepted term must equal SEED0, SEED1, then the sum of the two before it.
  task automatic mdl_step(input int i, input bit r, input bit v, input int d, input bit c);
    int e, s;
    bit cs;
    cs = (i == 0);
    m[i].match = 1'b0;
    if (r || c) begin
      m[i] = '{default: 0};
      return;
    end
    if (!v || m[i].failed) return;
    s = m[i].t1 + m[i].t2;
    e = m[i].n == 0 ? 0 : m[i].n == 1 ? 1 : s % MOD;
`ifdef FIBO_CHK_OVF_DETECT_EN
    if (m[i].n >= 2 && s >= MOD) m[i].ovf = 1'b1;
`endif
    if ((m[i].n >= 2 || cs) && d != e) begin
      m[i].failed = 1'b1;
      m[i].eidx = m[i].n > SAT ? SAT : m[i].n;
      m[i].eexp = e;
      m[i].egot = d;
    end else begin
      if (m[i].n >= 2) m[i].match = 1'b1;
      m[i].t2 = m[i].t1;
      m[i].t1 = d;
    end
    m[i].n++;
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.locked", i), locked[i], !m[i].failed && m[i].n >= 2);
      chk($sformatf("u%0d.match", i), match[i], m[i].match);
      chk($sformatf("u%0d.error", i), error[i], m[i].failed);
      chk($sformatf("u%0d.err_index", i), err_index[i], m[i].eidx);
      chk($sformatf("u%0d.err_expected", i), err_expected[i], m[i].eexp);
      chk($sformatf("u%0d.err_got", i), err_got[i], m[i].egot);
      chk($sformatf("u%0d.term_count", i), term_count[i], m[i].n > SAT ? SAT : m[i].n);
      chk($sformatf("u%0d.ovf", i), ovf[i], m[i].ovf);
    end
  endtask
  task automatic cycle(input bit r, input bit v, input int d, input bit c);
    rst = r;
    in_valid = v;
    in_data = W'(d);
    clear = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) mdl_step(i, r, v, d, c);
    #1 check_all();
  endtask
  task automatic feed(input int q [$], input bit gap);
    foreach (q[k]) begin
      cycle(1'b0, 1'b1, q[k], 1'b0);
      if (gap) cycle(1'b0, 1'b0, $urandom_range(MOD - 1), 1'b0);
    end
  endtask
  initial begin
    int a, b, t, gn;
    cycle(1'b1, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b1, 7, 1'b0);
    seq = {0, 1, 1, 2, 3, 5, 8, 13};
    feed(seq, 1'b0);
    chk("plan.count8", term_count[0], 8);
    seq = {21, 2, 23, 25};
    feed(seq, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    seq = {0, 1, 1, 2, 4, 7, 11};
    feed(seq, 1'b0);
    chk("plan.err_index", err_index[0], 4);
    chk("plan.frozen_count", term_count[0], 5);
    cycle(1'b0, 1'b0, 0, 1'b1);
    seq = {0, 0, 0, 0};
    feed(seq, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    seq = {2, 3, 5, 8, 13};
    feed(seq, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    seq = {0, 1, 1, 2, 3, 5, 8, 13, 21, 2, 23};
    feed(seq, 1'b1);
    cycle(1'b0, 1'b1, 25, 1'b1);
    seq = {0, 1, 1, 2};
    feed(seq, 1'b0);
    cycle(1'b1, 1'b1, 3, 1'b0);
    seq = {0, 1, 1, 9, 4};
    feed(seq, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b0);
    seq = {0, 1, 1, 2};
    feed(seq, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    a = 1; b = 0;
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b1, 1, 1'b0);
    for (int k = 0; k < 270; k++) begin
      t = (a + b) % MOD;
      b = a;
      a = t;
      cycle(1'b0, 1'b1, t, 1'b0);
    end
    gn = 0; a = 0; b = 0;
    for (int k = 0; k < 400; k++) begin
      bit r, c, v;
      int d;
      r = $urandom_range(59) == 0;
      c = $urandom_range(24) == 0;
      v = $urandom_range(3) != 0;
      d = gn == 0 ? 0 : gn == 1 ? 1 : (a + b) % MOD;
      if ($urandom_range(29) == 0) d = $urandom_range(MOD - 1);
      if (!v) d = $urandom_range(MOD - 1);
      cycle(r, v, d, c);
      if (r || c) begin
        gn = 0; a = 0; b = 0;
      end else if (v) begin
        b = a;
        a = d;
        gn++;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
